cache_arbiter: RTL and testbench



---
 rtl/cache_arbiter.sv | 141 ++++++++++++++
 tb/tb_cache_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Arbiter sharing one cacheline-wide memory port between the I-cache and D-cache.
// Requests are latched for the whole transaction; ties are resolved round-robin.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                  state_r, state_s;
    logic                    last_grant_r, last_grant_s;
    logic                    mem_read_r, mem_read_s;
    logic                    mem_write_r, mem_write_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [LINE_WIDTH-1:0]   wdata_r, wdata_s;
    logic [LINE_WIDTH-1:0]   rbuf_r, rbuf_s;
    logic                    iresp_r, iresp_s;
    logic                    dresp_r, dresp_s;
    logic                    i_req_s;
    logic                    d_req_s;

    // Next-state, latch and output-register logic for the arbitration FSM.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        mem_read_s   = mem_read_r;
        mem_write_s  = mem_write_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        rbuf_s       = rbuf_r;
        iresp_s      = 1'b0;
        dresp_s      = 1'b0;
        i_req_s      = icache_read;
        d_req_s      = dcache_read | dcache_write;

        case (state_r)
            IDLE: begin
                // D wins a tie only when I was served last; read+write together acts as a write.
                if (d_req_s && (!i_req_s || (last_grant_r == GRANT_I))) begin
                    state_s      = BUSY_D;
                    last_grant_s = GRANT_D;
                    addr_s       = dcache_address;
                    wdata_s      = dcache_wdata;
                    mem_write_s  = dcache_write;
                    mem_read_s   = ~dcache_write;
                end else if (i_req_s) begin
                    state_s      = BUSY_I;
                    last_grant_s = GRANT_I;
                    addr_s       = icache_address;
                    wdata_s      = {LINE_WIDTH{1'b0}};
                    mem_write_s  = 1'b0;
                    mem_read_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    state_s     = DONE;
                    rbuf_s      = mem_rdata;
                    mem_read_s  = 1'b0;
                    mem_write_s = 1'b0;
                    iresp_s     = (state_r == BUSY_I);
                    dresp_s     = (state_r == BUSY_D);
                end else begin
                    state_s = state_r;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s     = IDLE;
                mem_read_s  = 1'b0;
                mem_write_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_I;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            wdata_r      <= {LINE_WIDTH{1'b0}};
            rbuf_r       <= {LINE_WIDTH{1'b0}};
            iresp_r      <= 1'b0;
            dresp_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            mem_read_r   <= mem_read_s;
            mem_write_r  <= mem_write_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            rbuf_r       <= rbuf_s;
            iresp_r      <= iresp_s;
            dresp_r      <= dresp_s;
        end
    end

    assign mem_read     = mem_read_r;
    assign mem_write    = mem_write_r;
    assign mem_address  = addr_r;
    assign mem_wdata    = wdata_r;
    assign icache_rdata = rbuf_r;
    assign dcache_rdata = rbuf_r;
    assign icache_resp  = iresp_r;
    assign dcache_resp  = dresp_r;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a bench-side memory responder pushes expected
// responses into a scoreboard that is popped when the client resp pulse appears.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_read;
    logic [AW-1:0] icache_address;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic          dcache_read;
    logic          dcache_write;
    logic [AW-1:0] dcache_address;
    logic [LW-1:0] dcache_wdata;
    logic [LW-1:0] dcache_rdata;
    logic          dcache_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    typedef struct {
        logic          is_d;
        logic          is_write;
        logic [LW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a memory request and check its attributes and grant latency.
    task automatic start_txn(input string tag, input logic exp_write,
                             input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wdata);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(mem_read || mem_write) && n < 50);
        chk({tag, " grant_latency"}, LW'(n), LW'(1));
        chk({tag, " mem_write"}, LW'(mem_write), LW'(exp_write));
        chk({tag, " mem_read"}, LW'(mem_read), LW'(!exp_write));
        chk({tag, " mem_address"}, LW'(mem_address), LW'(exp_addr));
        if (exp_write) chk({tag, " mem_wdata"}, mem_wdata, exp_wdata);
    endtask

    // Hold the memory busy, respond, then check the single-cycle client response.
    task automatic finish_txn(input string tag, input logic is_d, input logic is_write,
                              input logic [AW-1:0] exp_addr, input logic [LW-1:0] rdata,
                              input int lat);
        exp_t e;
        repeat (lat) cyc();
        chk({tag, " hold_read"}, LW'(mem_read), LW'(!is_write));
        chk({tag, " hold_write"}, LW'(mem_write), LW'(is_write));
        chk({tag, " hold_address"}, LW'(mem_address), LW'(exp_addr));
        mem_rdata = rdata;
        mem_resp  = 1'b1;
        sb_q.push_back('{is_d: is_d, is_write: is_write, data: rdata});
        cyc();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        e = sb_q.pop_front();
        chk({tag, " icache_resp"}, LW'(icache_resp), LW'(!e.is_d));
        chk({tag, " dcache_resp"}, LW'(dcache_resp), LW'(e.is_d));
        chk({tag, " mem_idle_in_done"}, LW'({mem_read, mem_write}), LW'(2'b00));
        if (!e.is_write) begin
            chk({tag, " icache_rdata"}, icache_rdata, e.data);
            chk({tag, " dcache_rdata"}, dcache_rdata, e.data);
        end
        if (e.is_d) begin
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
        end else begin
            icache_read = 1'b0;
        end
        cyc();
        chk({tag, " resp_one_cycle"}, LW'({icache_resp, dcache_resp}), LW'(2'b00));
    endtask

    initial begin
        logic [LW-1:0] a5_line;
        logic [LW-1:0] beef_line;
        logic [LW-1:0] pat;
        int            resp_seen;
        a5_line   = {32{8'hA5}};
        beef_line = {8{32'hDEAD_BEEF}};

        rst            = 1'b1;
        icache_read    = 1'b0;
        icache_address = '0;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        mem_rdata      = '0;
        mem_resp       = 1'b0;
        repeat (2) cyc();
        chk("reset mem_rw", LW'({mem_read, mem_write}), LW'(2'b00));
        chk("reset resp", LW'({icache_resp, dcache_resp}), LW'(2'b00));
        chk("reset mem_address", LW'(mem_address), LW'(32'h0));
        chk("reset mem_wdata", mem_wdata, {LW{1'b0}});
        chk("reset rdata", icache_rdata, {LW{1'b0}});
        rst = 1'b0;
        cyc();

        // Lone I-fill
        icache_read    = 1'b1;
        icache_address = 32'h0000_0060;
        start_txn("ifill", 1'b0, 32'h0000_0060, '0);
        finish_txn("ifill", 1'b0, 1'b0, 32'h0000_0060, a5_line, 3);

        // Lone D write-back
        dcache_write   = 1'b1;
        dcache_address = 32'h0000_1000;
        dcache_wdata   = beef_line;
        start_txn("dwb", 1'b1, 32'h0000_1000, beef_line);
        finish_txn("dwb", 1'b1, 1'b1, 32'h0000_1000, {LW{1'b1}}, 4);

        // Illegal read+write is served as a write
        dcache_read    = 1'b1;
        dcache_write   = 1'b1;
        dcache_address = 32'h0000_2000;
        dcache_wdata   = {16{16'h1234}};
        start_txn("drw", 1'b1, 32'h0000_2000, {16{16'h1234}});
        finish_txn("drw", 1'b1, 1'b1, 32'h0000_2000, '0, 1);

        // Input change while busy
        dcache_read    = 1'b1;
        dcache_address = 32'h0000_0040;
        start_txn("dchg", 1'b0, 32'h0000_0040, '0);
        dcache_address = 32'h0000_0080;
        finish_txn("dchg", 1'b1, 1'b0, 32'h0000_0040, {8{32'h0BAD_F00D}}, 3);

        // Reset mid-transaction, then ties and fairness
        icache_read    = 1'b1;
        icache_address = 32'h0000_0300;
        start_txn("rst_mid", 1'b0, 32'h0000_0300, '0);
        rst = 1'b1;
        cyc();
        rst         = 1'b0;
        icache_read = 1'b0;
        chk("rst_mid mem_rw", LW'({mem_read, mem_write}), LW'(2'b00));
        chk("rst_mid mem_address", LW'(mem_address), LW'(32'h0));
        chk("rst_mid rdata", icache_rdata, {LW{1'b0}});
        resp_seen = 0;
        repeat (4) begin
            cyc();
            resp_seen += int'(icache_resp) + int'(dcache_resp);
        end
        chk("rst_mid no_resp", LW'(resp_seen), LW'(0));

        // Both request together: D then I, then D wins the next tie again; alternation continues
        icache_address = 32'h0000_0100;
        dcache_address = 32'h0000_0200;
        for (int k = 0; k < 6; k++) begin
            icache_read = 1'b1;
            dcache_read = 1'b1;
            pat = {8{32'(k) * 32'h1111_1111 + 32'h0101_0101}};
            if ((k % 2) == 0) begin
                start_txn("tie_d", 1'b0, 32'h0000_0200, '0);
                finish_txn("tie_d", 1'b1, 1'b0, 32'h0000_0200, pat, 2);
            end else begin
                start_txn("tie_i", 1'b0, 32'h0000_0100, '0);
                finish_txn("tie_i", 1'b0, 1'b0, 32'h0000_0100, pat, 2);
            end
        end
        icache_read = 1'b0;
        dcache_read = 1'b0;
        repeat (3) cyc();
        chk("final idle", LW'({mem_read, mem_write}), LW'(2'b00));
        chk("scoreboard empty", LW'(sb_q.size()), LW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
